// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    function automatic logic [1:0] stop_count(input logic [1:0] sbit);
        case (sbit)
            2'b00:   stop_count = 2'd1;
            2'b01:   stop_count = 2'd2;
            default: stop_count = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every limit+1 clk cycles, restartable via clear.
module uart_baud_tick (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [31:0] limit,
    output logic        tick
);

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || cnt >= limit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // >= keeps the counter from running away if limit drops below cnt
    assign tick = !clear && (cnt >= limit);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchroniser, 16x sampler and start/data/parity/stop deframer.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around the bit centre instead of a single sample.
//
// state  | meaning
// IDLE   | waiting for a synchronised falling edge with cr_rx_en high
// START  | counting to the centre of the start bit, false-start check
// DATA   | shifting in DATA_BITS samples, LSB first
// PARITY | sampling the parity bit and comparing against latched type
// STOP   | sampling 1..3 stop bits, publishing the frame after the last
// BREAK  | last stop bit was low; waiting for the line to return high
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rx,
    input  logic                 cr_rx_en,
    input  logic                 cr_pbit,
    input  logic                 cr_ptype,
    input  logic [1:0]           cr_sbit,
    input  logic [31:0]          cr_baud_limit,
    input  logic                 cr_baud_update,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_pbit_error,
    output logic                 rx_frame_error,
    output logic                 rx_valid_o,
    output logic                 rx_busy
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] START_DECIDE = 4'(SAMPLE_MID);
`else
    localparam logic [3:0] START_DECIDE = 4'(SAMPLE_MID - 1);
`endif

    rx_state_t             state;
    logic                  sync1, rx_s, rx_prev;
    logic                  tick, clear, decide, sample, start_edge;
    logic [3:0]            tick_cnt, bit_cnt;
    logic [1:0]            stop_cnt, stop_n;
    logic                  pbit_l, ptype_l, perr, ferr;
    logic [DATA_BITS-1:0]  shreg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign clear      = (state == IDLE) || cr_baud_update;
    assign start_edge = (state == IDLE) && cr_rx_en && rx_prev && !rx_s;
    assign rx_busy    = (state != IDLE);

    uart_baud_tick u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .limit   (cr_baud_limit),
        .tick    (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist[1] holds the tick before mid, hist[0] the mid tick; rx_s is mid+1
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        decide = 1'b0;
        if (tick) begin
            if (state == START) decide = (tick_cnt == START_DECIDE);
            else                decide = (tick_cnt == TICK_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            stop_cnt       <= 2'd1;
            stop_n         <= 2'd1;
            pbit_l         <= 1'b0;
            ptype_l        <= 1'b0;
            perr           <= 1'b0;
            ferr           <= 1'b0;
            shreg          <= '0;
            rx_data_o      <= '0;
            rx_pbit_error  <= 1'b0;
            rx_frame_error <= 1'b0;
            rx_valid_o     <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (state != IDLE && tick) begin
                tick_cnt <= decide ? 4'd0 : tick_cnt + 4'd1;
            end

            if (state != IDLE && (!cr_rx_en || cr_baud_update)) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        if (start_edge) begin
                            pbit_l   <= cr_pbit;
                            ptype_l  <= cr_ptype;
                            stop_n   <= stop_count(cr_sbit);
                            stop_cnt <= 2'd1;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            state    <= START;
                        end
                    end
                    START: begin
                        if (decide) state <= sample ? IDLE : DATA;
                    end
                    DATA: begin
                        if (decide) begin
                            shreg <= {sample, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= pbit_l ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (decide) begin
                            perr  <= (^{shreg, sample}) ^ ptype_l;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (decide) begin
                            ferr <= ferr | ~sample;
                            if (stop_cnt == stop_n) begin
                                rx_data_o      <= shreg;
                                rx_pbit_error  <= perr;
                                rx_frame_error <= ferr | ~sample;
                                rx_valid_o     <= 1'b1;
                                state          <= sample ? IDLE : BREAK;
                            end else begin
                                stop_cnt <= stop_cnt + 2'd1;
                            end
                        end
                    end
                    BREAK: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed scoreboard bench for uart_rx_sampler at 4 clk per tick (64 clk per bit).
module tb_uart_rx_sampler;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        uart_rx;
    logic        cr_rx_en;
    logic        cr_pbit;
    logic        cr_ptype;
    logic [1:0]  cr_sbit;
    logic [31:0] cr_baud_limit;
    logic        cr_baud_update;
    logic [7:0]  rx_data_o;
    logic        rx_pbit_error;
    logic        rx_frame_error;
    logic        rx_valid_o;
    logic        rx_busy;

    exp_t sb[$];
    exp_t got_exp;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;
    int   v0;
    logic [7:0] glitch_exp;

    uart_rx_sampler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .uart_rx        (uart_rx),
        .cr_rx_en       (cr_rx_en),
        .cr_pbit        (cr_pbit),
        .cr_ptype       (cr_ptype),
        .cr_sbit        (cr_sbit),
        .cr_baud_limit  (cr_baud_limit),
        .cr_baud_update (cr_baud_update),
        .rx_data_o      (rx_data_o),
        .rx_pbit_error  (rx_pbit_error),
        .rx_frame_error (rx_frame_error),
        .rx_valid_o     (rx_valid_o),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && rx_valid_o === 1'b1) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(sb.size()), 32'd1);
            end else begin
                got_exp = sb.pop_front();
                check("rx_data", 32'(rx_data_o), 32'(got_exp.data));
                check("rx_pbit_error", 32'(rx_pbit_error), 32'(got_exp.perr));
                check("rx_frame_error", 32'(rx_frame_error), 32'(got_exp.ferr));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par,
                              input int n_stop, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par);
        for (int i = 0; i < n_stop; i++) send_bit(stop_v);
    endtask

    initial begin
        reset_n        = 1'b0;
        uart_rx        = 1'b1;
        cr_rx_en       = 1'b0;
        cr_pbit        = 1'b0;
        cr_ptype       = 1'b0;
        cr_sbit        = 2'b00;
        cr_baud_limit  = 32'd3;
        cr_baud_update = 1'b0;
        idle(4);
        check("reset_data", 32'(rx_data_o), 32'h0);
        check("reset_perr", 32'(rx_pbit_error), 32'h0);
        check("reset_ferr", 32'(rx_frame_error), 32'h0);
        check("reset_valid", 32'(rx_valid_o), 32'h0);
        check("reset_busy", 32'(rx_busy), 32'h0);
        reset_n = 1'b1;
        idle(4);
        cr_rx_en = 1'b1;
        cr_baud_update = 1'b1;
        idle(1);
        cr_baud_update = 1'b0;
        idle(20);

        // 8N1 0xA5
        sb.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
        idle(20);
        check("a5_hold_data", 32'(rx_data_o), 32'hA5);
        check("a5_drain", 32'(sb.size()), 32'd0);

        // even parity, 0x03 with wrong then correct parity bit
        cr_pbit  = 1'b1;
        cr_ptype = 1'b0;
        sb.push_back('{8'h03, 1'b1, 1'b0});
        send_frame(8'h03, 1'b1, 1'b1, 1, 1'b1);
        idle(20);
        check("par_bad_hold", 32'(rx_pbit_error), 32'h1);
        sb.push_back('{8'h03, 1'b0, 1'b0});
        send_frame(8'h03, 1'b1, 1'b0, 1, 1'b1);
        idle(20);
        check("par_good_hold", 32'(rx_pbit_error), 32'h0);
        cr_pbit = 1'b0;

        // 20-clk false start
        v0 = n_valid;
        uart_rx = 1'b0;
        idle(10);
        check("false_start_busy_hi", 32'(rx_busy), 32'h1);
        idle(10);
        uart_rx = 1'b1;
        idle(40);
        check("false_start_busy_lo", 32'(rx_busy), 32'h0);
        check("false_start_no_valid", 32'(n_valid), 32'(v0));

        // low stop bit into a 200-clk break
        v0 = n_valid;
        sb.push_back('{8'h55, 1'b0, 1'b1});
        send_frame(8'h55, 1'b0, 1'b0, 1, 1'b0);
        idle(136);
        check("break_busy", 32'(rx_busy), 32'h1);
        check("break_one_valid", 32'(n_valid), 32'(v0 + 1));
        check("break_ferr_hold", 32'(rx_frame_error), 32'h1);
        uart_rx = 1'b1;
        idle(10);
        check("break_exit_busy", 32'(rx_busy), 32'h0);
        idle(100);
        check("break_no_more_valid", 32'(n_valid), 32'(v0 + 1));

        // abort on receiver disable mid-frame: no valid, outputs held
        v0 = n_valid;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("abort_busy_before", 32'(rx_busy), 32'h1);
        cr_rx_en = 1'b0;
        idle(1);
        check("abort_busy_after", 32'(rx_busy), 32'h0);
        idle(5);
        cr_rx_en = 1'b1;
        idle(700);
        check("abort_no_valid", 32'(n_valid), 32'(v0));
        check("abort_data_held", 32'(rx_data_o), 32'h55);
        check("abort_ferr_held", 32'(rx_frame_error), 32'h1);

        // two stop bits, back to back
        cr_sbit = 2'b01;
        v0 = n_valid;
        sb.push_back('{8'h55, 1'b0, 1'b0});
        sb.push_back('{8'hAA, 1'b0, 1'b0});
        send_frame(8'h55, 1'b0, 1'b0, 2, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 2, 1'b1);
        idle(20);
        check("b2b_valids", 32'(n_valid), 32'(v0 + 2));
        check("b2b_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'd704);
        cr_sbit = 2'b00;

        // reset asserted mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_data", 32'(rx_data_o), 32'h0);
        check("midreset_ferr", 32'(rx_frame_error), 32'h0);
        check("midreset_busy", 32'(rx_busy), 32'h0);
        @(negedge clk);
        uart_rx = 1'b1;
        idle(5);
        reset_n = 1'b1;
        idle(20);

        // inverted glitch at the centre of data bit 3 of 0x00
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        sb.push_back('{glitch_exp, 1'b0, 1'b0});
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        uart_rx = 1'b0;
        idle(30);
        uart_rx = 1'b1;
        idle(4);
        uart_rx = 1'b0;
        idle(30);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle(40);
        check("glitch_data_hold", 32'(rx_data_o), 32'(glitch_exp));
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
